// File: rtl/photon_pkg.sv
// Shared PHOTON-256 constants, GF(2^4) arithmetic and the state cell mapping.
// Cell (row i, col j) sits at state[255-4*(8i+j) -: 4], row-major, MSB first.
package photon_pkg;

  localparam int D      = 8;
  localparam int NROUND = 12;

  localparam logic [3:0] RC [12] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB,
                                     4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA};
  localparam logic [3:0] IC [8]  = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  localparam logic [3:0] Z  [8]  = '{4'h2, 4'h4, 4'h2, 4'hB, 4'h2, 4'h8, 4'h5, 4'h6};

  typedef enum logic [1:0] {IDLE, RND, MIX} fsm_e;

  // Carry-less product followed by reduction mod x^4+x+1.
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int k = 0; k < 4; k++)
      if (b[k]) p = p ^ (7'(a) << k);
    for (int k = 6; k >= 4; k--)
      if (p[k]) p = p ^ (7'b0010011 << (k - 4));
    return p[3:0];
  endfunction

  function automatic int cell_msb(input int i, input int j);
    return 255 - 4 * (8 * i + j);
  endfunction

endpackage

// File: rtl/photon_mix_step.sv
// One serial A-step on a column: shift cells up, append sum of Z[k]*c_k.
// Combinational; c0 occupies col[31:28].
module photon_mix_step
  import photon_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] col_next
);

  logic [3:0] acc;

  always_comb begin
    acc = '0;
    for (int k = 0; k < 8; k++)
      acc = acc ^ gf16_mul(Z[k], col[31-4*k -: 4]);
    col_next = {col[27:0], acc};
  end

endmodule

// File: rtl/photon_sbox.sv
// 4-bit PHOTON/PRESENT S-box, purely combinational.
module photon_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);

  always_comb begin
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
  end

endmodule

// File: rtl/photon_permutation.sv
// Iterative PHOTON-256 permutation: 12 rounds of 1 AC/SC/SR edge + 8 mix edges, done 108 edges after start.
// start is only sampled in IDLE; requests while busy are dropped, not queued.
module photon_permutation
  import photon_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] state_out
);

  fsm_e         fsm;
  logic [3:0]   round;
  logic [2:0]   step;
  logic [255:0] work;
  logic [255:0] ac, sb, sr, mx;
  logic [31:0]  col_in  [8];
  logic [31:0]  col_out [8];

  always_comb begin
    ac = work;
    for (int i = 0; i < 8; i++)
      ac[cell_msb(i, 0) -: 4] = work[cell_msb(i, 0) -: 4] ^ RC[round] ^ IC[i];
  end

  for (genvar k = 0; k < 64; k++) begin : g_sbox
    photon_sbox u_sbox (.x(ac[4*k +: 4]), .y(sb[4*k +: 4]));
  end

  // Row i rotates left by i cells.
  always_comb begin
    sr = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        sr[cell_msb(i, j) -: 4] = sb[cell_msb(i, (j + i) % 8) -: 4];
  end

  always_comb begin
    col_in = '{default: '0};
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        col_in[j][31-4*i -: 4] = work[cell_msb(i, j) -: 4];
  end

  for (genvar j = 0; j < 8; j++) begin : g_mix
    photon_mix_step u_mix (.col(col_in[j]), .col_next(col_out[j]));
  end

  always_comb begin
    mx = '0;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        mx[cell_msb(i, j) -: 4] = col_out[j][31-4*i -: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      round     <= '0;
      step      <= '0;
      work      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      state_out <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            work  <= state_in;
            round <= '0;
            step  <= '0;
            busy  <= 1'b1;
            fsm   <= RND;
          end
        end
        RND: begin
          work <= sr;
          step <= '0;
          fsm  <= MIX;
        end
        MIX: begin
          work <= mx;
          step <= step + 3'd1;
          if (step == 3'd7) begin
            if (round == 4'(NROUND - 1)) begin
              round     <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_out <= mx;
              fsm       <= IDLE;
            end else begin
              round <= round + 4'd1;
              fsm   <= RND;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_photon_permutation.sv
// Randomized bench for photon_permutation against a cell-array PHOTON-256 model.
module tb_photon_permutation;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] state_in;
  logic         busy, done;
  logic [255:0] state_out;
  logic [31:0]  mcol, mnext;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] SB_T [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] RC_T [12] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB,
                                       4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA};
  localparam logic [3:0] IC_T [8]  = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  localparam logic [3:0] Z_T  [8]  = '{4'h2, 4'h4, 4'h2, 4'hB, 4'h2, 4'h8, 4'h5, 4'h6};

  photon_permutation dut (
    .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
    .busy(busy), .done(done), .state_out(state_out)
  );

  photon_mix_step u_mix_unit (.col(mcol), .col_next(mnext));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // xtime-based multiply, independent of the RTL's reduction scheme.
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r, x;
    r = 0; x = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) r ^= x;
      x = x[3] ? ((x << 1) ^ 4'h3) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [255:0] photon_ref(input logic [255:0] s);
    logic [3:0] c [8][8];
    logic [3:0] t [8][8];
    logic [3:0] acc;
    logic [255:0] o;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) c[i][j] = s[255-4*(8*i+j) -: 4];
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 8; i++) c[i][0] ^= RC_T[r] ^ IC_T[i];
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) t[i][j] = SB_T[c[i][j]];
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) c[i][j] = t[i][(j + i) % 8];
      for (int j = 0; j < 8; j++)
        for (int n = 0; n < 8; n++) begin
          acc = 0;
          for (int k = 0; k < 8; k++) acc ^= gmul(Z_T[k], c[k][j]);
          for (int k = 0; k < 7; k++) c[k][j] = c[k+1][j];
          c[7][j] = acc;
        end
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) o[255-4*(8*i+j) -: 4] = c[i][j];
    return o;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  // Returns edges from acceptance to done (300 on timeout, -1 if reset was applied).
  task automatic run_one(input logic [255:0] s, input logic [255:0] alt, input bit alt_en,
                         input bit probe, input int rst_at, output int edges, output int lowbusy);
    logic [255:0] r1;
    int spurious;
    r1 = {64{4'hC}};
    for (int i = 0; i < 8; i++)
      r1[255-4*(8*i+((8-i)%8)) -: 4] = SB_T[4'h1 ^ IC_T[i]];
    @(negedge clk); state_in = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    check("busy_rise", busy, 1);
    edges = 0; lowbusy = 0;
    while (edges < 300) begin
      if (alt_en && (edges == 10 || edges == 60)) begin start = 1'b1; state_in = alt; end
      @(posedge clk); edges++;
      @(negedge clk); start = 1'b0; state_in = s;
      if (probe && edges == 1) check("round1_work", dut.work, r1);
      if (edges == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state_out", state_out, 0);
        check("rst_work", dut.work, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (150) begin
          @(negedge clk);
          if (done || busy) spurious++;
        end
        check("rst_no_done", spurious, 0);
        edges = -1;
        return;
      end
      if (done) break;
      if (!busy) lowbusy++;
    end
  endtask

  task automatic full_run(input string tag, input logic [255:0] s, input logic [255:0] alt,
                          input bit alt_en, input bit probe);
    int e, lb;
    run_one(s, alt, alt_en, probe, -1, e, lb);
    check({tag, "_latency"}, e, 108);
    check({tag, "_result"}, state_out, photon_ref(s));
    check({tag, "_busy_held"}, lb, 0);
    @(negedge clk);
    check({tag, "_done_single"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    logic [255:0] bb [3];
    logic [255:0] outs [3];
    logic [255:0] held;
    int tdone [3];
    int cyc, nd, unstable, e, lb;
    bit pend;
    logic [3:0] acc;

    rst_n = 1'b0; start = 1'b0; state_in = '0; mcol = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_state_out", state_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_work", dut.work, 0);

    full_run("zero", '0, '0, 1'b0, 1'b1);
    full_run("ignored", rand256(), rand256(), 1'b1, 1'b0);

    run_one(rand256(), '0, 1'b0, 1'b0, 50, e, lb);
    check("rst_aborted", e, -1);
    full_run("after_rst", rand256(), '0, 1'b0, 1'b0);
    full_run("rand", rand256(), '0, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin bb[k] = rand256(); tdone[k] = 0; outs[k] = '0; end
    @(negedge clk); state_in = bb[0]; start = 1'b1;
    @(posedge clk);
    @(negedge clk); state_in = bb[1];
    cyc = 0; nd = 0; pend = 0; unstable = 0; held = '0;
    while (nd < 3 && cyc < 400) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (pend) begin state_in = bb[2]; pend = 0; end
      if (done) begin
        tdone[nd] = cyc; outs[nd] = state_out; nd++;
        if (nd == 1) pend = 1;
        if (nd == 3) start = 1'b0;
        held = state_out;
      end else if (nd > 0 && state_out !== held) unstable++;
    end
    start = 1'b0;
    check("b2b_first", tdone[0], 108);
    check("b2b_gap1", tdone[1] - tdone[0], 109);
    check("b2b_gap2", tdone[2] - tdone[1], 109);
    for (int k = 0; k < 3; k++) check($sformatf("b2b_out%0d", k), outs[k], photon_ref(bb[k]));
    check("b2b_stable", unstable, 0);

    mcol = 32'h1000_0000; #1;
    check("mix_unit_c0", mnext, 32'h0000_0002);
    acc = 0;
    for (int k = 0; k < 8; k++) acc ^= gmul(Z_T[k], 4'hF);
    mcol = 32'hFFFF_FFFF; #1;
    check("mix_all_f", mnext, {28'hFFF_FFFF, acc});
    for (int n = 0; n < 4; n++) begin
      mcol = $urandom(); #1;
      acc = 0;
      for (int k = 0; k < 8; k++) acc ^= gmul(Z_T[k], mcol[31-4*k -: 4]);
      check("mix_rand", mnext, {mcol[27:0], acc});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
